// File: rtl/alu_test_pkg.sv
// Shared definitions for the alu_test harness: ALU op codes, sequencer states,
// machine trap causes and the test vector record layout.
package alu_test_pkg;

  // op = {funct7[5], funct3}
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_rv32i.sv
// Combinational RV32I integer ALU. Shifts take the low log2(XLEN) bits of b;
// unknown op codes produce zero.
module alu_rv32i
  import alu_test_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_signed;
  logic           lt_unsigned;

  assign shamt       = b[SHW-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLL:  y = a << shamt;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $unsigned($signed(a) >>> shamt);
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_test.sv
// ALU exercise harness: sequencer walks the vector ROM through alu_rv32i and
// counts results. Define ALU_TEST_IRQ_EN to enable machine interrupt trapping.
module alu_test
  import alu_test_pkg::*;
#(
  parameter int NUM_VEC = 10,
  parameter int XLEN    = 32
) (
  input logic clk,
  input logic rst_n,
  input logic m_ext_irq,
  input logic m_time_irq,
  input logic m_soft_irq
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  state_t          state, state_d;
  logic [3:0]      vec_idx, vec_idx_d;
  logic [XLEN-1:0] alu_result, alu_result_d;
  logic [7:0]      pass_cnt, pass_cnt_d;
  logic [7:0]      fail_cnt, fail_cnt_d;
  logic            done, done_d;
  logic [31:0]     mcause, mcause_d;
  logic [7:0]      trap_cnt, trap_cnt_d;
  logic [2:0]      irq_pend, irq_pend_d;
  logic [2:0]      irq_q, irq_q_d;

  vec_t            cur_vec;
  logic [XLEN-1:0] alu_y;
  logic            run_vector;

`ifdef ALU_TEST_IRQ_EN
  logic [2:0]      irq_rise;
  logic [2:0]      irq_clr;
`else
  logic            unused_irq;
  assign unused_irq = m_ext_irq ^ m_time_irq ^ m_soft_irq;
`endif

  function automatic vec_t rom_entry(input logic [3:0] idx);
    vec_t v;
    case (idx)
      4'd0:    v = '{OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
      4'd1:    v = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
      4'd2:    v = '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
      4'd3:    v = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      4'd4:    v = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      4'd5:    v = '{OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
      4'd6:    v = '{OP_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
      4'd7:    v = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
      4'd8:    v = '{OP_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
      4'd9:    v = '{OP_AND,  32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
      default: v = '0;
    endcase
    return v;
  endfunction

  assign cur_vec = rom_entry(vec_idx);

  alu_rv32i #(.XLEN(XLEN)) u_alu (
    .op (cur_vec.op),
    .a  (cur_vec.a),
    .b  (cur_vec.b),
    .y  (alu_y)
  );

  always_comb begin
    state_d      = state;
    vec_idx_d    = vec_idx;
    alu_result_d = alu_result;
    pass_cnt_d   = pass_cnt;
    fail_cnt_d   = fail_cnt;
    done_d       = done;
    mcause_d     = mcause;
    trap_cnt_d   = trap_cnt;
    irq_pend_d   = irq_pend;
    irq_q_d      = irq_q;
    run_vector   = 1'b0;
`ifdef ALU_TEST_IRQ_EN
    irq_clr  = 3'b000;
    // Bit order {ext, soft, time} matches the trap priority, MSB first.
    irq_q_d  = {m_ext_irq, m_soft_irq, m_time_irq};
    irq_rise = irq_q_d & ~irq_q;
`endif

    case (state)
      ST_RUN: begin
`ifdef ALU_TEST_IRQ_EN
        if (irq_pend != 3'b000) begin
          state_d    = ST_TRAP;
          trap_cnt_d = sat_inc8(trap_cnt);
          if (irq_pend[2]) begin
            mcause_d = MCAUSE_MEI;
            irq_clr  = 3'b100;
          end else if (irq_pend[1]) begin
            mcause_d = MCAUSE_MSI;
            irq_clr  = 3'b010;
          end else begin
            mcause_d = MCAUSE_MTI;
            irq_clr  = 3'b001;
          end
        end else begin
          run_vector = 1'b1;
        end
`else
        run_vector = 1'b1;
`endif
      end
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_DONE;
    endcase

    if (run_vector) begin
      alu_result_d = alu_y;
      if (alu_y == cur_vec.exp) pass_cnt_d = sat_inc8(pass_cnt);
      else                      fail_cnt_d = sat_inc8(fail_cnt);
      if (vec_idx == LAST_IDX) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        vec_idx_d = vec_idx + 4'd1;
      end
    end

`ifdef ALU_TEST_IRQ_EN
    // A fresh edge on a source being serviced this cycle stays pending.
    irq_pend_d = (irq_pend & ~irq_clr) | irq_rise;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      vec_idx    <= '0;
      alu_result <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      done       <= 1'b0;
      mcause     <= '0;
      trap_cnt   <= '0;
      irq_pend   <= '0;
      irq_q      <= '0;
    end else begin
      state      <= state_d;
      vec_idx    <= vec_idx_d;
      alu_result <= alu_result_d;
      pass_cnt   <= pass_cnt_d;
      fail_cnt   <= fail_cnt_d;
      done       <= done_d;
      mcause     <= mcause_d;
      trap_cnt   <= trap_cnt_d;
      irq_pend   <= irq_pend_d;
      irq_q      <= irq_q_d;
    end
  end

endmodule

// File: tb/tb_alu_test.sv
// Bench for alu_test: behavioural model stepped on every rising edge, compared
// against the internal probes on every falling edge, plus directed literal checks.
module tb_alu_test;
  import alu_test_pkg::*;

  localparam int NUM_VEC = 10;
  localparam int PH_RUN  = 0;
  localparam int PH_TRAP = 1;
  localparam int PH_DONE = 2;

  logic clk;
  logic rst_n;
  logic m_ext_irq;
  logic m_time_irq;
  logic m_soft_irq;

  int n_checks = 0;
  int n_pass   = 0;

  // Vector table as written in the specification, plus the literal result stream.
  logic [3:0]  t_op [NUM_VEC] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                  4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  logic [31:0] t_a  [NUM_VEC] = '{32'h00000005, 32'h00000003, 32'h00000001, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFF00FF00, 32'h80000000, 32'h80000000,
                                  32'h0000F0F0, 32'h12345678};
  logic [31:0] t_b  [NUM_VEC] = '{32'h00000003, 32'h00000005, 32'h0000001F, 32'h00000001,
                                  32'h00000001, 32'h0F0F0F0F, 32'h00000024, 32'h00000004,
                                  32'h00000F0F, 32'h0F0F0F0F};
  logic [31:0] t_exp[NUM_VEC] = '{32'h00000008, 32'hFFFFFFFE, 32'h80000000, 32'h00000001,
                                  32'h00000000, 32'hF00FF00F, 32'h08000000, 32'hF8000000,
                                  32'h0000FFFF, 32'h02040608};
  logic [31:0] exp_q[$];

  // Behavioural model state
  int          m_phase;
  int          m_idx;
  logic [31:0] m_res;
  int          m_pass;
  int          m_fail;
  int          m_trap;
  bit          m_done;
  logic [31:0] m_mcause;
  logic [2:0]  m_prev;
  logic [2:0]  m_pend;

  alu_test #(.NUM_VEC(NUM_VEC), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_ext_irq  (m_ext_irq),
    .m_time_irq (m_time_irq),
    .m_soft_irq (m_soft_irq)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int s;
    logic [31:0] r;
    s = int'(b & 32'h1F);
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a + (~b + 32'd1);
      4'b0001: r = a << s;
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> s;
      4'b1101: r = (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'd0);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_reset();
    m_phase  = PH_RUN;
    m_idx    = 0;
    m_res    = 32'd0;
    m_pass   = 0;
    m_fail   = 0;
    m_trap   = 0;
    m_done   = 1'b0;
    m_mcause = 32'd0;
    m_prev   = 3'b000;
    m_pend   = 3'b000;
  endtask

  task automatic model_step();
    logic [2:0] cur;
    logic [2:0] rise;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef ALU_TEST_IRQ_EN
    cur = {m_ext_irq, m_soft_irq, m_time_irq};
`else
    cur = 3'b000;
`endif
    rise   = cur & ~m_prev;
    m_prev = cur;
    if (m_phase == PH_RUN) begin
      if (m_pend != 3'b000) begin
        if (m_pend[2]) begin
          m_mcause = 32'h8000000B; m_pend[2] = 1'b0;
        end else if (m_pend[1]) begin
          m_mcause = 32'h80000003; m_pend[1] = 1'b0;
        end else begin
          m_mcause = 32'h80000007; m_pend[0] = 1'b0;
        end
        m_trap  = sat255(m_trap);
        m_phase = PH_TRAP;
      end else begin
        m_res = model_alu(t_op[m_idx], t_a[m_idx], t_b[m_idx]);
        if (m_res == t_exp[m_idx]) m_pass = sat255(m_pass);
        else                       m_fail = sat255(m_fail);
        if (m_idx == NUM_VEC - 1) begin
          m_phase = PH_DONE;
          m_done  = 1'b1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (m_phase == PH_TRAP) begin
      m_phase = PH_RUN;
    end
    m_pend = m_pend | rise;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] phase_to_state(input int ph);
    if (ph == PH_TRAP) return 32'(ST_TRAP);
    if (ph == PH_DONE) return 32'(ST_DONE);
    return 32'(ST_RUN);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_vec_idx",    32'(dut.vec_idx),    32'(m_idx));
      check("cyc_alu_result", dut.alu_result,      m_res);
      check("cyc_pass_cnt",   32'(dut.pass_cnt),   32'(m_pass));
      check("cyc_fail_cnt",   32'(dut.fail_cnt),   32'(m_fail));
      check("cyc_done",       32'(dut.done),       32'(m_done));
      check("cyc_state",      32'(dut.state),      phase_to_state(m_phase));
      check("cyc_mcause",     dut.mcause,          m_mcause);
      check("cyc_trap_cnt",   32'(dut.trap_cnt),   32'(m_trap));
      check("cyc_irq_pend",   32'(dut.irq_pend),   32'(m_pend));
      check("cyc_irq_q",      32'(dut.irq_q),      32'(m_prev));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n;
    n = 0;
    while (dut.done !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dut.done), 32'd1);
  endtask

  task automatic check_reset_probes(input string tag);
    check({tag, "_vec_idx"},    32'(dut.vec_idx),  32'd0);
    check({tag, "_alu_result"}, dut.alu_result,    32'd0);
    check({tag, "_pass_cnt"},   32'(dut.pass_cnt), 32'd0);
    check({tag, "_fail_cnt"},   32'(dut.fail_cnt), 32'd0);
    check({tag, "_done"},       32'(dut.done),     32'd0);
    check({tag, "_state"},      32'(dut.state),    32'(ST_RUN));
    check({tag, "_mcause"},     dut.mcause,        32'd0);
    check({tag, "_trap_cnt"},   32'(dut.trap_cnt), 32'd0);
    check({tag, "_irq_pend"},   32'(dut.irq_pend), 32'd0);
    check({tag, "_irq_q"},      32'(dut.irq_q),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    m_ext_irq  = 1'b0;
    m_time_irq = 1'b0;
    m_soft_irq = 1'b0;

    for (int i = 0; i < NUM_VEC; i++)
      check("model_pin", model_alu(t_op[i], t_a[i], t_b[i]), t_exp[i]);

    // Reset state, then release at 20 ns.
    @(negedge clk);
    check_reset_probes("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain walk: one result per edge, done on the tenth edge.
    for (int i = 0; i < NUM_VEC; i++) exp_q.push_back(t_exp[i]);
    for (int i = 0; i < NUM_VEC; i++) begin
      logic [31:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check("walk_result", dut.alu_result, e);
      check("walk_done", 32'(dut.done), (i == NUM_VEC - 1) ? 32'd1 : 32'd0);
    end
    check("walk_pass", 32'(dut.pass_cnt), 32'd10);
    check("walk_fail", 32'(dut.fail_cnt), 32'd0);
    check("walk_trap", 32'(dut.trap_cnt), 32'd0);
    idle(3);
    check("walk_hold", dut.alu_result, 32'h02040608);

    // External interrupt pulse of three cycles mid-walk.
    do_reset();
    idle(6);
    m_ext_irq = 1'b1;
    idle(3);
    m_ext_irq = 1'b0;
    wait_done("ext_done", 40);
`ifdef ALU_TEST_IRQ_EN
    check("ext_trap_cnt", 32'(dut.trap_cnt), 32'd1);
    check("ext_mcause",   dut.mcause,        32'h8000000B);
`else
    check("ext_trap_cnt", 32'(dut.trap_cnt), 32'd0);
    check("ext_mcause",   dut.mcause,        32'd0);
`endif
    check("ext_pass", 32'(dut.pass_cnt), 32'd10);

    // Soft and timer rise together: soft is serviced first.
    do_reset();
    idle(2);
    m_soft_irq = 1'b1;
    m_time_irq = 1'b1;
    idle(2);
`ifdef ALU_TEST_IRQ_EN
    check("dual_first", dut.mcause, 32'h80000003);
`else
    check("dual_first", dut.mcause, 32'd0);
`endif
    idle(2);
`ifdef ALU_TEST_IRQ_EN
    check("dual_second", dut.mcause, 32'h80000007);
`else
    check("dual_second", dut.mcause, 32'd0);
`endif
    m_soft_irq = 1'b0;
    m_time_irq = 1'b0;
    wait_done("dual_done", 40);
`ifdef ALU_TEST_IRQ_EN
    check("dual_trap_cnt", 32'(dut.trap_cnt), 32'd2);
`else
    check("dual_trap_cnt", 32'(dut.trap_cnt), 32'd0);
`endif
    check("dual_pass", 32'(dut.pass_cnt), 32'd10);

    // One-cycle reset in the middle of a walk.
    do_reset();
    idle(4);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_probes("mid");
    rst_n = 1'b1;
    wait_done("mid_done", 30);
    check("mid_pass", 32'(dut.pass_cnt), 32'd10);

    // Random interrupt toggling with occasional resets.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) m_ext_irq  = ~m_ext_irq;
      if ($urandom_range(0, 3) == 0) m_soft_irq = ~m_soft_irq;
      if ($urandom_range(0, 3) == 0) m_time_irq = ~m_time_irq;
      rst_n = ($urandom_range(0, 39) != 0);
    end
    @(negedge clk);
    m_ext_irq  = 1'b0;
    m_soft_irq = 1'b0;
    m_time_irq = 1'b0;
    rst_n      = 1'b1;
    do_reset();
    wait_done("final_done", 30);
    check("final_pass", 32'(dut.pass_cnt), 32'd10);
    check("final_fail", 32'(dut.fail_cnt), 32'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
